// File: rtl/uart_rx_buffer_pkg.sv
// Shared definitions for the UART receive buffer: data width, default depth
// and the handshake FSM state encoding.
package uart_rx_buffer_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/uart_rx_buffer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// rd_data is read combinationally from the array and forced to zero when empty.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              rx_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty = (count == '0);
  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  // a full FIFO can still take a write when the head leaves on the same edge
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge rx_clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: acknowledges each completed byte from the receiver,
// stores it in a FIFO and presents it to the host with occupancy/overflow status.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic                    rx_clk,
  input  logic                    reset,
  input  logic [UART_DATA_W-1:0]  rx_data,
  input  logic                    rx_complete_flag,
  output logic                    rx_complete_del_flag,
  output logic [UART_DATA_W-1:0]  rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ADDR_W:0]         count,
  output logic                    full,
  output logic                    overflow,
  input  logic                    clear_overflow
);

  rx_state_e state;
  rx_state_e state_next;
  logic      del_next;
  logic      overflow_next;
  logic      wr_en;
  logic      drop;
  logic      empty;
  logic      pop;

  assign rd_valid = ~empty;
  assign pop      = rd_valid & rd_ready;

  sync_fifo #(
    .WIDTH  (UART_DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .rx_clk  (rx_clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (rx_data),
    .rd_en   (rd_ready),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state                <= ST_IDLE;
      rx_complete_del_flag <= 1'b0;
      overflow             <= 1'b0;
    end else begin
      state                <= state_next;
      rx_complete_del_flag <= del_next;
      overflow             <= overflow_next;
    end
  end

  always_comb begin
    state_next = state;
    del_next   = 1'b0;
    wr_en      = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_complete_flag) begin
          del_next   = 1'b1;
          state_next = ST_ACK;
          if (!full || pop) begin
            wr_en = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_ACK: begin
        // hold the acknowledge until the receiver drops its flag
        if (rx_complete_flag) begin
          del_next = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    overflow_next = clear_overflow ? 1'b0 : (overflow | drop);
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Downstream consumer of the UART receiver.
- Detects each completed byte on rx_data / rx_complete_flag, stores it in a synchronous FIFO, and returns the rx_complete_del_flag acknowledge that releases the receiver to idle.
- Presents buffered bytes to the host side through a first-word-fall-through valid/ready interface, with occupancy and overflow status.
- Runs on the receiver's oversampling clock domain, so no CDC is needed.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- rx_clk  in  1  single clock, rising edge; same clock as the receiver.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the receiver; valid while rx_complete_flag=1.
- rx_complete_flag  in  1  receiver "byte ready" level.
- rx_complete_del_flag  out  1  acknowledge to the receiver.
- rd_data  out  8  FIFO head byte; valid when rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  host pop; a pop occurs only when rd_valid & rd_ready.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- clear_overflow  in  1  clears overflow; takes priority over a same-cycle set.

Behaviour:
- Reset values: rx_complete_del_flag=0, overflow=0, count=0, rd_valid=0, full=0, pointers=0, rd_data=8'h00 (memory contents are don't-care), FSM=IDLE.
- Reset mid-operation discards all FIFO contents and any pending acknowledge, with no partial write.
- FSM IDLE:
  - On the cycle where rx_complete_flag=1, capture rx_data.
  - If the FIFO is not full, or a pop occurs in the same cycle, write the byte at the next edge.
  - Otherwise drop the byte and set overflow.
  - Go to ACK.
- FSM ACK:
  - rx_complete_del_flag=1, registered, starting the edge after capture.
  - Hold it while rx_complete_flag=1.
  - When rx_complete_flag=0, drive rx_complete_del_flag=0 at the next edge and go to IDLE.
  - Exactly one write per flag assertion, including a one-cycle flag pulse (the receiver's bad-stop pulse). A one-cycle pulse still writes and still produces a one-cycle acknowledge.
- Flag already high again on return to IDLE: treated as a new byte (back-to-back frames).
- Latency:
  - Flag high at edge N: write and count update at N+1, rd_valid=1 at N+1 when the FIFO was empty, rx_complete_del_flag=1 at N+1.
  - No empty-bypass path.
- FIFO:
  - Circular pointers of width ADDR_W wrap from DEPTH-1 to 0.
  - count += write - pop. Simultaneous write and pop leaves count unchanged.
  - A pop when empty is ignored.
  - rd_data = mem[rd_ptr], combinational from the register array.
  - full and rd_valid are derived from count.
- Overflow: the sticky bit sets on any drop; clear_overflow=1 clears it.

Decomposition:
- Shared header uart_defs.vh holds:
  - UART_DATA_W=8;
  - the FSM state encodings (IDLE=1'b0, ACK=1'b1);
  - the default DEPTH.
- Sub-module sync_fifo, parameterised by width/DEPTH/ADDR_W:
  - ports: wr_en, wr_data, rd_en, rd_data, count, full, empty.
- uart_rx_buffer holds the handshake FSM and overflow logic.

Test Plan:
- Single byte: flag=1 with rx_data=8'hA5 held until the acknowledge, then flag=0.
  - Required: del_flag high one edge after the flag, low one edge after the flag drops; rd_valid=1, rd_data=8'hA5, count=1.
  - Then pop: rd_valid=0, count=0.
- Burst of 16 bytes 8'h00..8'h0F with no pops.
  - Required: full=1, count=16, overflow=0.
  - Then pop all 16 in order 00..0F with rd_ready held high; empty at the end.
- Overflow: with the FIFO full, send 8'hEE.
  - Required: acknowledge still issued, count stays 16, overflow=1, 8'hEE never read.
  - Assert clear_overflow together with another dropped byte: overflow=0.
- Full with simultaneous pop: with the FIFO full, send 8'h77 while rd_ready=1.
  - Required: head popped, 8'h77 accepted, count=16, overflow=0, 8'h77 is the last byte read.
- One-cycle flag pulse with rx_data=8'h3C.
  - Required: exactly one write of 8'h3C, one-cycle del_flag, FSM back in IDLE.
  - Then the flag held for 40 cycles with 8'h3D: exactly one additional write.
- Reset mid-ACK with 3 bytes stored.
  - Required: next cycle del_flag=0, count=0, rd_valid=0, overflow=0.
  - A subsequent byte 8'h5A is written and read normally.
